// File: rtl/d_ff_pkg.sv
// Shared definitions for the d_ff_pipeline delay line.
package d_ff_pkg;

  // Default data value loaded into every stage on reset or flush.
  localparam int DEFAULT_RESET_VAL = 0;

  // Width of the occupancy counter: it must hold every value from 0 to depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipeline_if.sv
// Data/qualifier bus of the d_ff_pipeline delay line.
interface d_ff_pipeline_if
  import d_ff_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  localparam int CW = count_width(DEPTH);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    count;

  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid, count
  );

  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid, count
  );
endinterface

// File: rtl/d_ff_en_stage.sv
// One pipeline stage: register with async reset, sync clear and enable.
module d_ff_en_stage #(
  parameter int           W         = 2,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Clear wins over enable; without either the stage holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_q <= RESET_VAL;
    else if (i_clr) r_q <= RESET_VAL;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/d_ff_pipeline.sv
// WIDTH-bit, DEPTH-stage clock-enabled delay line carrying a valid bit per
// stage, with a running count of valid stages in flight.
module d_ff_pipeline
  import d_ff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input logic             clk,
  input logic             rst,
  d_ff_pipeline_if.slave  bus
);
  localparam int CW = count_width(DEPTH);

  // Each stage stores {data, valid}; valid sits in bit 0.
  logic [WIDTH:0]   w_stage_q [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [CW-1:0]    r_count;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH:0] w_stage_d;

    if (g == 0) begin : g_head
      assign w_stage_d = {bus.d, bus.d_valid};
    end else begin : g_body
      assign w_stage_d = w_stage_q[g-1];
    end

    d_ff_en_stage #(
      .W         (WIDTH + 1),
      .RESET_VAL ({RESET_VAL, 1'b0})
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .i_clr (bus.flush),
      .i_en  (bus.en),
      .i_d   (w_stage_d),
      .o_q   (w_stage_q[g])
    );

    assign w_valid[g] = w_stage_q[g][0];
  end

  // Incremental occupancy: a valid entering adds one, a valid leaving the
  // last stage subtracts one. Range stays within 0..DEPTH by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_count <= '0;
    else if (bus.flush) r_count <= '0;
    else if (bus.en)    r_count <= r_count + CW'(bus.d_valid) - CW'(w_valid[DEPTH-1]);
  end

  assign bus.q       = w_stage_q[DEPTH-1][WIDTH:1];
  assign bus.q_valid = w_valid[DEPTH-1];
  assign bus.count   = r_count;

  // The incremental counter must always agree with the valid bits it tracks.
  a_count_popcount: assert property (
    @(posedge clk) disable iff (rst) r_count == CW'($countones(w_valid))
  );
endmodule
